// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between MEM stage and SRAM controller.
// Define CACHE_STATS_EN to add saturating read hit/miss counters (hitCountOut, missCountOut).
module cache_controller #(
   parameter int SETS  = 64,
   parameter int TAG_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addrIn,
   input  logic [31:0] wdataIn,
   input  logic        rdEnIn,
   input  logic        wrEnIn,
   output logic [31:0] rdataOut,
   output logic        readyOut,
   output logic [31:0] sramAddrOut,
   output logic [31:0] sramWdataOut,
   output logic        sramRdEnOut,
   output logic        sramWrEnOut,
   input  logic [63:0] sramRdataIn,
   input  logic        sramReadyIn
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0] hitCountOut,
   output logic [15:0] missCountOut
`endif
);

   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_LO = 3 + IDX_W;

   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

   state_t state_reg, state_next;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             word_sel;

   assign idx      = addrIn[3 +: IDX_W];
   assign tag      = addrIn[TAG_LO +: TAG_W];
   assign word_sel = addrIn[2];

   logic [1:0]  hit_way;
   logic [1:0]  way_valid;
   logic [63:0] way_line [2];
   logic [1:0]  fill_mask;
   logic [1:0]  wr_mask;
   logic [SETS-1:0] lru_reg;

   logic        any_hit;
   logic        victim;
   logic        fill_en;
   logic        wr_hit_en;
   logic        rd_hit;
   logic [63:0] hit_line;
   logic [31:0] hit_word;

   assign any_hit   = |hit_way;
   assign fill_en   = (state_reg == RD_MISS) && sramReadyIn;
   assign wr_hit_en = (state_reg == WR_THRU) && sramReadyIn && any_hit;
   assign rd_hit    = (state_reg == IDLE) && rdEnIn && !wrEnIn && any_hit;

   // Invalid ways fill first (way0 before way1); otherwise lru=1 names way1 as victim.
   assign victim    = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_reg[idx]);
   assign fill_mask = fill_en ? (victim ? 2'b10 : 2'b01) : 2'b00;
   assign wr_mask   = wr_hit_en ? (hit_way[0] ? 2'b01 : 2'b10) : 2'b00;

   assign hit_line  = hit_way[0] ? way_line[0] : way_line[1];
   assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_way
         logic [SETS-1:0]  valid_reg;
         logic [TAG_W-1:0] tag_mem  [SETS];
         logic [63:0]      data_mem [SETS];

         assign way_valid[gi] = valid_reg[idx];
         assign hit_way[gi]   = valid_reg[idx] && (tag_mem[idx] == tag);
         assign way_line[gi]  = data_mem[idx];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               valid_reg <= '0;
            end else if (fill_mask[gi]) begin
               valid_reg[idx] <= 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (fill_mask[gi]) begin
               tag_mem[idx]  <= tag;
               data_mem[idx] <= sramRdataIn;
            end else if (wr_mask[gi]) begin
               if (word_sel) begin
                  data_mem[idx][63:32] <= wdataIn;
               end else begin
                  data_mem[idx][31:0] <= wdataIn;
               end
            end
         end
      end
   endgenerate

   // lru=1 records way0 as most recently used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lru_reg <= '0;
      end else if (fill_en) begin
         lru_reg[idx] <= ~victim;
      end else if (rd_hit || wr_hit_en) begin
         lru_reg[idx] <= hit_way[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      readyOut     = 1'b1;
      rdataOut     = 32'd0;
      sramRdEnOut  = 1'b0;
      sramWrEnOut  = 1'b0;
      sramAddrOut  = 32'd0;
      sramWdataOut = 32'd0;
      // Reset forces the idle output values even while a request is presented.
      if (!rst) begin
         case (state_reg)
            IDLE: begin
               if (wrEnIn) begin
                  state_next = WR_THRU;
                  readyOut   = 1'b0;
               end else if (rdEnIn) begin
                  if (any_hit) begin
                     rdataOut = hit_word;
                  end else begin
                     state_next = RD_MISS;
                     readyOut   = 1'b0;
                  end
               end
            end
            RD_MISS: begin
               sramRdEnOut = 1'b1;
               sramAddrOut = {addrIn[31:3], 3'b000};
               readyOut    = sramReadyIn;
               if (sramReadyIn) begin
                  rdataOut   = word_sel ? sramRdataIn[63:32] : sramRdataIn[31:0];
                  state_next = IDLE;
               end
            end
            WR_THRU: begin
               sramWrEnOut  = 1'b1;
               sramAddrOut  = addrIn;
               sramWdataOut = wdataIn;
               readyOut     = sramReadyIn;
               if (sramReadyIn) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_reg;
   logic [15:0] miss_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_reg  <= 16'd0;
         miss_cnt_reg <= 16'd0;
      end else begin
         if (rd_hit && (hit_cnt_reg != 16'hFFFF)) begin
            hit_cnt_reg <= hit_cnt_reg + 16'd1;
         end
         if (fill_en && (miss_cnt_reg != 16'hFFFF)) begin
            miss_cnt_reg <= miss_cnt_reg + 16'd1;
         end
      end
   end

   assign hitCountOut  = hit_cnt_reg;
   assign missCountOut = miss_cnt_reg;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
